// File: rtl/md_unit_if.sv
// Bus between the execute stage and the multiply/divide unit.
// The core (master) issues operations and reads HI/LO.
// The unit (slave) reports busy/done and the HI/LO contents.
interface md_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// An accepted mult/div holds busy for a fixed latency, then commits HI/LO
// together with a one-cycle done pulse. mthi/mtlo write HI/LO directly.
// Results come from operands latched at the accepting edge, so the core may
// change a/b freely while the operation is in flight.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    md_unit_if.slave  bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2:0]         op_q, op_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic               done_q, done_d;

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        abs_a;
    logic [31:0]        abs_b;
    logic [31:0]        den_s;
    logic [31:0]        den_u;
    logic [31:0]        mag_q;
    logic [31:0]        mag_r;
    logic [31:0]        div_q;
    logic [31:0]        div_r;
    logic [31:0]        divu_q;
    logic [31:0]        divu_r;

    // Arithmetic results from the latched operands; signed divide is done on
    // magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
    always_comb begin
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        abs_a  = a_q[31] ? (~a_q + 32'd1) : a_q;
        abs_b  = b_q[31] ? (~b_q + 32'd1) : b_q;
        den_s  = (b_q == 32'd0) ? 32'd1 : abs_b;
        den_u  = (b_q == 32'd0) ? 32'd1 : b_q;
        mag_q  = abs_a / den_s;
        mag_r  = abs_a % den_s;
        div_q  = (a_q[31] ^ b_q[31]) ? (~mag_q + 32'd1) : mag_q;
        div_r  = a_q[31] ? (~mag_r + 32'd1) : mag_r;
        divu_q = a_q / den_u;
        divu_r = a_q % den_u;
    end

    // Next-state logic: accept work only in IDLE, count down in RUN, commit on the last count.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            op_d    = bus.op;
                            a_d     = bus.a;
                            b_d     = bus.b;
                            count_d = CNT_W'(MULT_CYCLES);
                            state_d = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            op_d    = bus.op;
                            a_d     = bus.a;
                            b_d     = bus.b;
                            count_d = CNT_W'(DIV_CYCLES);
                            state_d = RUN;
                        end
                        OP_MTHI: hi_d = bus.a;
                        OP_MTLO: lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (count_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    count_d = '0;
                    done_d  = 1'b1;
                    case (op_q)
                        OP_MULT:  {hi_d, lo_d} = prod_s;
                        OP_MULTU: {hi_d, lo_d} = prod_u;
                        OP_DIV: begin
                            if (b_q != 32'd0) begin
                                hi_d = div_r;
                                lo_d = div_q;
                            end
                        end
                        OP_DIVU: begin
                            if (b_q != 32'd0) begin
                                hi_d = divu_r;
                                lo_d = divu_q;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and data registers; reset aborts any in-flight operation without committing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
